rx_uart: RTL and testbench

Serial receiver for the UART link: recovers start + data + optional parity + stop frames from `serial_in` and presents each word on a parallel output with a one-cycle valid strobe. It is the receive-side counterpart of the team's transmitter: LSB-first data, idle-high line, one start bit (0), one stop bit (1). It sits between the pad-side serial input and the receive data sink. It uses a single system clock and an oversampling tick enable generated by the shared baud generator.

---
 rtl/rx_uart_if.sv | 23 ++
 rtl/rx_uart.sv | 167 ++++++++++++++++
 tb/tb_rx_uart.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/rx_uart_if.sv
// Bundles the line-side inputs and the parallel word outputs of rx_uart.
// The master side drives the tick and line inputs; the slave side is the receiver.
interface rx_uart_if #(
    parameter int unsigned INPUT_DATA_WIDTH = 8
);
    logic                        sample_tick;
    logic                        serial_in;
    logic [INPUT_DATA_WIDTH-1:0] o_data;
    logic                        o_valid;
    logic                        o_parity_err;
    logic                        o_frame_err;
    logic                        o_busy;

    modport master (
        output sample_tick, serial_in,
        input  o_data, o_valid, o_parity_err, o_frame_err, o_busy
    );

    modport slave (
        input  sample_tick, serial_in,
        output o_data, o_valid, o_parity_err, o_frame_err, o_busy
    );
endinterface

// File: rtl/rx_uart.sv
// Oversampling UART receiver: start + LSB-first data + optional even parity + stop.
// Define RX_MAJORITY_VOTE_EN for 2-of-3 voting around each bit centre.
module rx_uart #(
    parameter int unsigned INPUT_DATA_WIDTH = 8,
    parameter int unsigned PARITY_ENABLED   = 1,
    parameter int unsigned OVERSAMPLE       = 16
) (
    input logic     clk,
    input logic     reset,
    rx_uart_if.slave bus
);
    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = (INPUT_DATA_WIDTH > 1) ? $clog2(INPUT_DATA_WIDTH) : 1;
`ifdef RX_MAJORITY_VOTE_EN
    localparam int unsigned START_PT = OVERSAMPLE / 2;
`else
    localparam int unsigned START_PT = OVERSAMPLE / 2 - 1;
`endif
    localparam logic [TW-1:0] START_CNT = TW'(START_PT);
    localparam logic [TW-1:0] BIT_CNT   = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(INPUT_DATA_WIDTH - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t                      state_q, state_d;
    logic                        armed_q, armed_d;
    logic [TW-1:0]               tcnt_q, tcnt_d;
    logic [BW-1:0]               bcnt_q, bcnt_d;
    logic [INPUT_DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                        par_q, par_d;
    logic [INPUT_DATA_WIDTH-1:0] data_q, data_d;
    logic                        valid_q, valid_d;
    logic                        perr_q, perr_d;
    logic                        ferr_q, ferr_d;
    logic [1:0]                  sync_q;
    logic                        rx_s;
    logic                        sample;

    assign rx_s = sync_q[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= '1;
        else       sync_q <= {sync_q[0], bus.serial_in};
    end

`ifdef RX_MAJORITY_VOTE_EN
    // Decision point is one tick past centre, so history holds centre-1 and centre.
    logic [1:0] hist_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                hist_q <= '1;
        else if (bus.sample_tick) hist_q <= {hist_q[0], rx_s};
    end

    assign sample = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
    assign sample = rx_s;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            armed_q <= 1'b0;
            tcnt_q  <= '0;
            bcnt_q  <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            tcnt_q  <= tcnt_d;
            bcnt_q  <= bcnt_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        armed_d = armed_q;
        tcnt_d  = tcnt_q;
        bcnt_d  = bcnt_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        data_d  = data_q;
        valid_d = 1'b0;
        perr_d  = perr_q;
        ferr_d  = ferr_q;

        if (bus.sample_tick) begin
            unique case (state_q)
                S_IDLE: begin
                    if (rx_s) begin
                        armed_d = 1'b1;
                    end else if (armed_q) begin
                        state_d = S_START;
                        tcnt_d  = '0;
                    end
                end
                S_START: begin
                    if (tcnt_q == START_CNT) begin
                        if (sample) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_DATA;
                            tcnt_d  = '0;
                            bcnt_d  = '0;
                            par_d   = 1'b0;
                        end
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
                S_DATA: begin
                    if (tcnt_q == BIT_CNT) begin
                        tcnt_d = '0;
                        shreg_d = shreg_q >> 1;
                        shreg_d[INPUT_DATA_WIDTH-1] = sample;
                        if (bcnt_q == LAST_BIT)
                            state_d = (PARITY_ENABLED != 0) ? S_PARITY : S_STOP;
                        else
                            bcnt_d = bcnt_q + BW'(1);
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
                S_PARITY: begin
                    if (tcnt_q == BIT_CNT) begin
                        tcnt_d  = '0;
                        par_d   = (^shreg_q) ^ sample;
                        state_d = S_STOP;
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
                S_STOP: begin
                    if (tcnt_q == BIT_CNT) begin
                        tcnt_d  = '0;
                        data_d  = shreg_q;
                        perr_d  = (PARITY_ENABLED != 0) && par_q;
                        ferr_d  = ~sample;
                        valid_d = 1'b1;
                        armed_d = sample;
                        state_d = S_IDLE;
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign bus.o_data       = data_q;
    assign bus.o_valid      = valid_q;
    assign bus.o_parity_err = perr_q;
    assign bus.o_frame_err  = ferr_q;
    assign bus.o_busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_rx_uart.sv
// Directed bench for rx_uart: frame table plus break, glitch, drift and reset sequences.
module tb_rx_uart;
    localparam int unsigned W        = 8;
    localparam int unsigned OS       = 16;
    localparam int unsigned TICK_DIV = 8;
    localparam int unsigned BIT_T    = OS * TICK_DIV * 10;
    localparam int unsigned BIT_SLOW = 1318;
    localparam int unsigned BIT_FAST = 1242;
`ifdef RX_MAJORITY_VOTE_EN
    localparam int unsigned EXP_BUSY = (OS / 2 + OS * 10 + 1) * TICK_DIV;
`else
    localparam int unsigned EXP_BUSY = (OS / 2 + OS * 10) * TICK_DIV;
`endif

    typedef struct {
        logic [7:0] d;
        logic       p;
        logic       s;
        logic [7:0] exp_d;
        logic       exp_pe;
        logic       exp_fe;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    int          total = 0;
    int          bad = 0;
    int          vcnt = 0;
    int          busy_cnt = 0;
    int          v0;
    int unsigned div = 0;
    logic [7:0]  cap_d = '0;
    logic        cap_pe = 1'b0;
    logic        cap_fe = 1'b0;
    logic [7:0]  dq[$];
    vec_t        tbl[8];

    always #5 clk = ~clk;

    rx_uart_if #(.INPUT_DATA_WIDTH(W)) bus ();

    rx_uart #(
        .INPUT_DATA_WIDTH(W),
        .PARITY_ENABLED(1),
        .OVERSAMPLE(OS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always @(negedge clk) begin
        bus.sample_tick = (div == TICK_DIV - 1);
        div = (div == TICK_DIV - 1) ? 0 : div + 1;
    end

    always @(negedge clk) begin
        if (bus.o_valid) begin
            vcnt++;
            cap_d  = bus.o_data;
            cap_pe = bus.o_parity_err;
            cap_fe = bus.o_frame_err;
            dq.push_back(bus.o_data);
        end
        if (bus.o_busy) busy_cnt++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                              input int unsigned bit_t, input int unsigned nbits);
        logic [10:0] fr;
        fr = {s, p, d, 1'b0};
        for (int unsigned i = 0; i < nbits; i++) begin
            bus.serial_in = fr[i];
            #(bit_t);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_data"}, 32'(bus.o_data), 32'h0);
        chk({nm, "_valid"}, 32'(bus.o_valid), 32'h0);
        chk({nm, "_perr"}, 32'(bus.o_parity_err), 32'h0);
        chk({nm, "_ferr"}, 32'(bus.o_frame_err), 32'h0);
        chk({nm, "_busy"}, 32'(bus.o_busy), 32'h0);
    endtask

    initial begin
        // parity column: even parity over data+parity, so odd-weight data needs p=1
        tbl[0] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0};
        tbl[1] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        tbl[2] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
        tbl[3] = '{8'h55, 1'b1, 1'b1, 8'h55, 1'b1, 1'b0};
        tbl[4] = '{8'h7F, 1'b1, 1'b1, 8'h7F, 1'b0, 1'b0};
        tbl[5] = '{8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
        tbl[6] = '{8'h12, 1'b0, 1'b0, 8'h12, 1'b0, 1'b1};
        tbl[7] = '{8'hC3, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b1};

        reset = 1'b1;
        bus.serial_in = 1'b1;
        repeat (5) @(negedge clk);
        chk_zero("in_reset");
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk_zero("after_reset");

        busy_cnt = 0;
        v0 = vcnt;
        send_frame(8'hA5, 1'b0, 1'b1, BIT_T, 11);
        bus.serial_in = 1'b1;
        #(2 * BIT_T);
        chk("a5_count", 32'(vcnt - v0), 32'd1);
        chk("a5_data", 32'(cap_d), 32'hA5);
        chk("a5_perr", 32'(cap_pe), 32'h0);
        chk("a5_ferr", 32'(cap_fe), 32'h0);
        chk("a5_busy_cycles", 32'(busy_cnt), 32'(EXP_BUSY));

        for (int i = 0; i < 8; i++) begin
            v0 = vcnt;
            send_frame(tbl[i].d, tbl[i].p, tbl[i].s, BIT_T, 11);
            bus.serial_in = 1'b1;
            #(2 * BIT_T);
            chk($sformatf("vec%0d_count", i), 32'(vcnt - v0), 32'd1);
            chk($sformatf("vec%0d_data", i), 32'(cap_d), 32'(tbl[i].exp_d));
            chk($sformatf("vec%0d_perr", i), 32'(cap_pe), 32'(tbl[i].exp_pe));
            chk($sformatf("vec%0d_ferr", i), 32'(cap_fe), 32'(tbl[i].exp_fe));
        end

        // Stop bit 0 followed by a held-low break: one errored word, then silence.
        v0 = vcnt;
        send_frame(8'h81, 1'b0, 1'b0, BIT_T, 11);
        #(33 * BIT_T);
        chk("brk_count", 32'(vcnt - v0), 32'd1);
        chk("brk_data", 32'(cap_d), 32'h81);
        chk("brk_ferr", 32'(cap_fe), 32'h1);
        chk("brk_busy", 32'(bus.o_busy), 32'h0);
        bus.serial_in = 1'b1;
        #(2 * BIT_T);
        chk("brk_release_count", 32'(vcnt - v0), 32'd1);
        send_frame(8'h81, 1'b0, 1'b1, BIT_T, 11);
        #(2 * BIT_T);
        chk("brk_clean_count", 32'(vcnt - v0), 32'd2);
        chk("brk_clean_data", 32'(cap_d), 32'h81);
        chk("brk_clean_ferr", 32'(cap_fe), 32'h0);
        chk("brk_clean_perr", 32'(cap_pe), 32'h0);

        v0 = vcnt;
        bus.serial_in = 1'b0;
        #(4 * TICK_DIV * 10);
        bus.serial_in = 1'b1;
        #(2 * BIT_T);
        chk("glitch_count", 32'(vcnt - v0), 32'd0);
        chk("glitch_busy", 32'(bus.o_busy), 32'h0);

`ifdef RX_MAJORITY_VOTE_EN
        v0 = vcnt;
        bus.serial_in = 1'b0;
        #(BIT_T);
        for (int i = 0; i < 8; i++) begin
            bus.serial_in = 1'b1;
            if (i == 3) begin
                #(BIT_T / 2 - TICK_DIV * 5);
                bus.serial_in = 1'b0;
                #(TICK_DIV * 10);
                bus.serial_in = 1'b1;
                #(BIT_T / 2 - TICK_DIV * 5);
            end else begin
                #(BIT_T);
            end
        end
        bus.serial_in = 1'b0;
        #(BIT_T);
        bus.serial_in = 1'b1;
        #(3 * BIT_T);
        chk("vote_count", 32'(vcnt - v0), 32'd1);
        chk("vote_data", 32'(cap_d), 32'hFF);
        chk("vote_perr", 32'(cap_pe), 32'h0);
`endif

        v0 = vcnt;
        send_frame(8'h00, 1'b0, 1'b1, BIT_SLOW, 11);
        send_frame(8'hFF, 1'b0, 1'b1, BIT_SLOW, 11);
        send_frame(8'h55, 1'b0, 1'b1, BIT_SLOW, 11);
        #(2 * BIT_T);
        chk("slow_count", 32'(vcnt - v0), 32'd3);
        if (vcnt - v0 == 3) begin
            chk("slow_d0", 32'(dq[v0]), 32'h00);
            chk("slow_d1", 32'(dq[v0 + 1]), 32'hFF);
            chk("slow_d2", 32'(dq[v0 + 2]), 32'h55);
        end

        v0 = vcnt;
        send_frame(8'h00, 1'b0, 1'b1, BIT_FAST, 11);
        send_frame(8'hFF, 1'b0, 1'b1, BIT_FAST, 11);
        send_frame(8'h55, 1'b0, 1'b1, BIT_FAST, 6);
        chk("fast_busy_mid", 32'(bus.o_busy), 32'h1);
        reset = 1'b1;
        bus.serial_in = 1'b1;
        #100;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("midreset");
        #(2 * BIT_T);
        chk("fast_count", 32'(vcnt - v0), 32'd2);
        if (vcnt - v0 >= 2) begin
            chk("fast_d0", 32'(dq[v0]), 32'h00);
            chk("fast_d1", 32'(dq[v0 + 1]), 32'hFF);
        end
        chk_zero("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
